dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter APR, default 48, width of phase increment driven to the NCO.
REQ-002 Parameter NSW, default 16, width of the step-count field.
REQ-003 Parameter DWW, default 16, width of the dwell-count field.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_start_inc  in  APR  first phase increment of the sweep.
REQ-007 cfg_step  in  APR  per-step increment delta, two's complement.
REQ-008 cfg_nsteps  in  NSW  number of steps after the first frequency.
REQ-009 cfg_dwell  in  DWW  extra hold cycles per frequency; each frequency lasts cfg_dwell+1 cycles.
REQ-010 cfg_repeat  in  1  0 = single sweep, 1 = restart from cfg_start_inc indefinitely.
REQ-011 start  in  1  level-sampled request to begin a sweep.
REQ-012 abort  in  1  level-sampled request to stop immediately.
REQ-013 nco_valid  in  1  NCO out_valid.
REQ-014 phi_inc_o  out  APR  phase increment to NCO phi_inc_i.
REQ-015 nco_clken  out  1  NCO clock enable.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 seg_strobe  out  1  one-cycle pulse each cycle phi_inc_o takes a new value.
REQ-018 done  out  1  one-cycle pulse on normal single-sweep completion.

Function
REQ-019 FSM states SHALL be IDLE, WARM and RUN; all outputs SHALL be registered.
REQ-020 In IDLE, start=1 and abort=0 SHALL do all of the following:
- Latch all cfg_* inputs into shadow registers.
- Load phi_inc_o with cfg_start_inc and pulse seg_strobe.
- Load dwell_cnt with cfg_dwell and clear step_cnt.
- Enter WARM.
REQ-021 cfg_* inputs SHALL be ignored outside the start-acceptance cycle; start SHALL be ignored while busy=1.
REQ-022 nco_clken SHALL be 1 in WARM and RUN and 0 in IDLE.
REQ-023 In WARM, dwell_cnt SHALL hold, and the first cycle with nco_valid=1 SHALL move the FSM to RUN.
REQ-024 In RUN with dwell_cnt>0, dwell_cnt SHALL decrement by 1 per cycle.
REQ-025 In RUN with dwell_cnt=0 and step_cnt<nsteps:
- phi_inc_o <= phi_inc_o + step, modulo 2^APR.
- step_cnt increments and dwell_cnt reloads.
- seg_strobe pulses.
REQ-026 In RUN with dwell_cnt=0, step_cnt=nsteps and repeat=1:
- phi_inc_o <= start_inc; step_cnt clears and dwell_cnt reloads.
- seg_strobe pulses and the FSM stays in RUN.
REQ-027 In RUN with dwell_cnt=0, step_cnt=nsteps and repeat=0: the FSM SHALL enter IDLE, pulse done and hold phi_inc_o.
REQ-028 nsteps=0 SHALL produce one frequency lasting dwell+1 RUN cycles, then done (or a reload if repeat=1).
REQ-029 abort=1 in any state SHALL force IDLE on the next edge:
- No done or seg_strobe pulse.
- phi_inc_o held; counters cleared.
REQ-030 abort SHALL take priority over start and over every RUN transition in the same cycle.
REQ-031 nco_valid falling while in RUN SHALL have no effect.
REQ-032 Arithmetic wrap SHALL be silent, with no saturation and no flag.

Reset
REQ-033 While reset_n=0, outputs SHALL be:
- phi_inc_o=0, nco_clken=0, busy=0, seg_strobe=0, done=0.
- FSM in IDLE, dwell_cnt=0, step_cnt=0, shadow registers all zero.
REQ-034 Reset assertion mid-sweep SHALL take effect asynchronously. After release, the block SHALL behave as after power-up and need a new start.

Verification
REQ-035 Stimulus: start_inc=0x1000, step=0x10, nsteps=3, dwell=2, repeat=0, nco_valid=1 from the 4th WARM cycle.
Required response:
- phi_inc_o sequence 0x1000, 0x1010, 0x1020, 0x1030, each held 3 RUN cycles.
- 4 seg_strobe pulses total.
- One done pulse, then busy=0 and phi_inc_o=0x1030.
REQ-036 Stimulus: start_inc=0x000000000005, step=0xFFFFFFFFFFFE (−2), nsteps=3, dwell=0. Required response: phi_inc_o = 5, 3, 1, 0xFFFFFFFFFFFF, one cycle each.
REQ-037 Stimulus: repeat=1, start_inc=0x100, step=0x100, nsteps=1, dwell=1, run 12 RUN cycles. Required response: 0x100, 0x200, 0x100, 0x200 ... each held 2 cycles, with no done pulse.
REQ-038 Stimulus: abort and start asserted together in RUN, second step active. Required response: IDLE next cycle, nco_clken=0, phi_inc_o holds the step-2 value, no done pulse, and the start is not accepted.
REQ-039 Stimulus: start during RUN with different cfg_* values. Required response: ignored; the sweep continues with the latched values.
REQ-040 Stimulus: reset_n pulsed low mid-dwell between clock edges. Required response: all outputs zero immediately; start held high after release begins a fresh sweep on the first clock edge.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - linear frequency-sweep controller driving an NCO phase increment
module dds_sweep_ctrl #(
    parameter int APR = 48,
    parameter int NSW = 16,
    parameter int DWW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [APR-1:0] cfg_start_inc,
    input  logic [APR-1:0] cfg_step,
    input  logic [NSW-1:0] cfg_nsteps,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic           cfg_repeat,
    input  logic           start,
    input  logic           abort,
    input  logic           nco_valid,
    output logic [APR-1:0] phi_inc_o,
    output logic           nco_clken,
    output logic           busy,
    output logic           seg_strobe,
    output logic           done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [APR-1:0] sh_start_inc, sh_start_inc_n;
    logic [APR-1:0] sh_step, sh_step_n;
    logic [NSW-1:0] sh_nsteps, sh_nsteps_n;
    logic [DWW-1:0] sh_dwell, sh_dwell_n;
    logic           sh_repeat, sh_repeat_n;
    logic [DWW-1:0] dwell_cnt, dwell_cnt_n;
    logic [NSW-1:0] step_cnt, step_cnt_n;
    logic [APR-1:0] phi_n;
    logic           strobe_n;
    logic           done_n;
    logic           busy_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            sh_start_inc <= '0;
            sh_step      <= '0;
            sh_nsteps    <= '0;
            sh_dwell     <= '0;
            sh_repeat    <= 1'b0;
            dwell_cnt    <= '0;
            step_cnt     <= '0;
            phi_inc_o    <= '0;
            seg_strobe   <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            nco_clken    <= 1'b0;
        end else begin
            state        <= state_n;
            sh_start_inc <= sh_start_inc_n;
            sh_step      <= sh_step_n;
            sh_nsteps    <= sh_nsteps_n;
            sh_dwell     <= sh_dwell_n;
            sh_repeat    <= sh_repeat_n;
            dwell_cnt    <= dwell_cnt_n;
            step_cnt     <= step_cnt_n;
            phi_inc_o    <= phi_n;
            seg_strobe   <= strobe_n;
            done         <= done_n;
            busy         <= busy_n;
            nco_clken    <= busy_n;
        end
    end

    always_comb begin
        state_n        = state;
        sh_start_inc_n = sh_start_inc;
        sh_step_n      = sh_step;
        sh_nsteps_n    = sh_nsteps;
        sh_dwell_n     = sh_dwell;
        sh_repeat_n    = sh_repeat;
        dwell_cnt_n    = dwell_cnt;
        step_cnt_n     = step_cnt;
        phi_n          = phi_inc_o;
        strobe_n       = 1'b0;
        done_n         = 1'b0;

        // Abort outranks both start acceptance and every RUN transition.
        if (abort) begin
            state_n     = S_IDLE;
            dwell_cnt_n = '0;
            step_cnt_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_start_inc_n = cfg_start_inc;
                        sh_step_n      = cfg_step;
                        sh_nsteps_n    = cfg_nsteps;
                        sh_dwell_n     = cfg_dwell;
                        sh_repeat_n    = cfg_repeat;
                        phi_n          = cfg_start_inc;
                        strobe_n       = 1'b1;
                        dwell_cnt_n    = cfg_dwell;
                        step_cnt_n     = '0;
                        state_n        = S_WARM;
                    end
                end
                S_WARM: begin
                    if (nco_valid) begin
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt_n = dwell_cnt - 1'b1;
                    end else if (step_cnt != sh_nsteps) begin
                        phi_n       = phi_inc_o + sh_step;
                        step_cnt_n  = step_cnt + 1'b1;
                        dwell_cnt_n = sh_dwell;
                        strobe_n    = 1'b1;
                    end else if (sh_repeat) begin
                        phi_n       = sh_start_inc;
                        step_cnt_n  = '0;
                        dwell_cnt_n = sh_dwell;
                        strobe_n    = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

    localparam int APR = 48;
    localparam int NSW = 16;
    localparam int DWW = 16;

    logic           clk;
    logic           reset_n;
    logic [APR-1:0] cfg_start_inc;
    logic [APR-1:0] cfg_step;
    logic [NSW-1:0] cfg_nsteps;
    logic [DWW-1:0] cfg_dwell;
    logic           cfg_repeat;
    logic           start;
    logic           abort;
    logic           nco_valid;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken;
    logic           busy;
    logic           seg_strobe;
    logic           done;

    int checks;
    int failures;
    int strobes;

    dds_sweep_ctrl #(.APR(APR), .NSW(NSW), .DWW(DWW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_start_inc(cfg_start_inc),
        .cfg_step     (cfg_step),
        .cfg_nsteps   (cfg_nsteps),
        .cfg_dwell    (cfg_dwell),
        .cfg_repeat   (cfg_repeat),
        .start        (start),
        .abort        (abort),
        .nco_valid    (nco_valid),
        .phi_inc_o    (phi_inc_o),
        .nco_clken    (nco_clken),
        .busy         (busy),
        .seg_strobe   (seg_strobe),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [APR-1:0] si, input logic [APR-1:0] st,
                           input logic [NSW-1:0] ns, input logic [DWW-1:0] dw, input logic rp);
        cfg_start_inc = si;
        cfg_step      = st;
        cfg_nsteps    = ns;
        cfg_dwell     = dw;
        cfg_repeat    = rp;
    endtask

    task automatic check_idle(input string tag, input logic [APR-1:0] exp_phi, input logic exp_done);
        check({tag, "_busy"},   64'(busy), 64'd0);
        check({tag, "_clken"},  64'(nco_clken), 64'd0);
        check({tag, "_strobe"}, 64'(seg_strobe), 64'd0);
        check({tag, "_done"},   64'(done), 64'(exp_done));
        check({tag, "_phi"},    64'(phi_inc_o), 64'(exp_phi));
    endtask

    logic [APR-1:0] t2_exp [4];

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        nco_valid = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0);
        t2_exp[0] = 48'h5;
        t2_exp[1] = 48'h3;
        t2_exp[2] = 48'h1;
        t2_exp[3] = 48'hFFFF_FFFF_FFFF;

        repeat (2) @(negedge clk);
        check_idle("reset", '0, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic sweep: 4 frequencies, 3 RUN cycles each, nco_valid late in WARM.
        set_cfg(48'h1000, 48'h10, 16'd3, 16'd2, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        strobes = 0;
        check("t1_warm_phi", 64'(phi_inc_o), 64'h1000);
        check("t1_warm_strobe", 64'(seg_strobe), 64'd1);
        check("t1_warm_busy", 64'(busy), 64'd1);
        check("t1_warm_clken", 64'(nco_clken), 64'd1);
        strobes += int'(seg_strobe);
        repeat (2) @(negedge clk);
        check("t1_warm3_strobe", 64'(seg_strobe), 64'd0);
        @(negedge clk);
        nco_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("t1_run%0d_phi", k), 64'(phi_inc_o), 64'h1000 + 64'h10 * 64'(k / 3));
            check($sformatf("t1_run%0d_strobe", k), 64'(seg_strobe), 64'((k % 3 == 0) && (k > 0)));
            check($sformatf("t1_run%0d_done", k), 64'(done), 64'd0);
            strobes += int'(seg_strobe);
            // Start with different cfg while busy must be ignored.
            if (k == 4) begin
                set_cfg(48'hAAAA, 48'h1, 16'd9, 16'd0, 1'b1);
                start = 1'b1;
            end
            if (k == 6) start = 1'b0;
        end
        @(negedge clk);
        check_idle("t1_end", 48'h1030, 1'b1);
        check("t1_strobe_total", 64'(strobes), 64'd4);
        @(negedge clk);
        check_idle("t1_after", 48'h1030, 1'b0);

        // Negative step with zero dwell, wrapping below zero.
        set_cfg(48'h5, 48'hFFFF_FFFF_FFFE, 16'd3, 16'd0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t2_run%0d_phi", k), 64'(phi_inc_o), 64'(t2_exp[k]));
            check($sformatf("t2_run%0d_strobe", k), 64'(seg_strobe), 64'(k > 0));
        end
        @(negedge clk);
        check_idle("t2_end", 48'hFFFF_FFFF_FFFF, 1'b1);

        // Repeat mode, then abort at a reload point.
        set_cfg(48'h100, 48'h100, 16'd1, 16'd1, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("t3_run%0d_phi", k), 64'(phi_inc_o), ((k / 2) % 2 == 1) ? 64'h200 : 64'h100);
            check($sformatf("t3_run%0d_done", k), 64'(done), 64'd0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("t3_abort", 48'h200, 1'b0);

        // Abort together with start during the second step.
        set_cfg(48'h1000, 48'h10, 16'd3, 16'd2, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) @(negedge clk);
        check("t4_step2_phi", 64'(phi_inc_o), 64'h1020);
        set_cfg(48'h5555, 48'h1, 16'd1, 16'd0, 1'b0);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_idle("t4_abort", 48'h1020, 1'b0);
        @(negedge clk);
        check_idle("t4_after", 48'h1020, 1'b0);

        // Asynchronous reset mid-dwell, start held across release.
        set_cfg(48'h2000, 48'h1, 16'd2, 16'd5, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_run_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_idle("t5_async", '0, 1'b0);
        set_cfg(48'h777, 48'h1, 16'd0, 16'd0, 1'b0);
        start = 1'b1;
        #1 reset_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_restart_busy", 64'(busy), 64'd1);
        check("t5_restart_phi", 64'(phi_inc_o), 64'h777);
        check("t5_restart_strobe", 64'(seg_strobe), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
